matrix_mult_seq: RTL and testbench

Sequential, parametrised successor of the combinational-array matrix multiplier: computes R = A × B for an M×K matrix A and a K×N matrix B using a single time-multiplexed multiply-accumulate unit, one product per clock.
- Adds a full-width accumulator, a signed/unsigned mode, selectable saturation or wrap on output, an overflow flag, and a start/busy/done handshake.
- Sits in the matrix operations datapath wherever area matters more than latency.

---
 rtl/matrix_mult_pkg.sv | 74 +++++++
 rtl/matrix_mult_seq_mac_unit.sv | 38 +++
 rtl/matrix_mult_seq.sv | 188 ++++++++++++++++++
 tb/tb_matrix_mult_seq.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// rtl/matrix_mult_pkg.sv - shared types and helpers for the sequential matrix multiplier
// State encoding, width derivation, element offsets and result conversion.
package matrix_mult_pkg;

  typedef enum logic {IDLE, MAC} state_t;

  // Conversion works on a fixed wide container; callers extend into it.
  localparam int CONV_W = 64;

  typedef struct packed {
    logic [CONV_W-1:0] value;
    logic              ovf;
  } conv_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + clog2(k);
  endfunction

  function automatic int a_offset(input int r, input int c, input int k, input int dw);
    return (r * k + c) * dw;
  endfunction

  function automatic int b_offset(input int r, input int c, input int n, input int dw);
    return (r * n + c) * dw;
  endfunction

  function automatic int r_offset(input int r, input int c, input int n, input int ow);
    return (r * n + c) * ow;
  endfunction

  // value holds the clamped result when sat is set, otherwise the raw input
  // (the caller keeps the low ow bits, which is the wrap behaviour).
  function automatic conv_t convert(input logic [CONV_W-1:0] v, input int ow,
                                    input logic sgn, input logic sat);
    conv_t                    res;
    logic signed [CONV_W-1:0] sv;
    logic signed [CONV_W-1:0] hi;
    logic signed [CONV_W-1:0] lo;
    logic        [CONV_W-1:0] uhi;
    sv        = $signed(v);
    hi        = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo        = -hi - 64'sd1;
    uhi       = (ow >= CONV_W) ? '1 : ((64'd1 << ow) - 64'd1);
    res.value = v;
    res.ovf   = 1'b0;
    if (sgn) begin
      if (sv > hi) begin
        res.ovf = 1'b1;
        if (sat) res.value = hi;
      end else if (sv < lo) begin
        res.ovf = 1'b1;
        if (sat) res.value = lo;
      end
    end else if (v > uhi) begin
      res.ovf = 1'b1;
      if (sat) res.value = uhi;
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_mac_unit.sv
// rtl/matrix_mult_seq_mac_unit.sv - single multiply-accumulate unit
// Operands are extended per mode into the accumulator width; arithmetic is mod 2^ACC_WIDTH.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_signed,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_sum
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] a_x, b_x, prod;

  // Low ACC_WIDTH bits of the product depend only on the low bits of the
  // extended operands, so a narrow multiply is exact for the accumulator.
  assign a_x   = {{(ACC_WIDTH-DATA_WIDTH){i_signed & i_a[DATA_WIDTH-1]}}, i_a};
  assign b_x   = {{(ACC_WIDTH-DATA_WIDTH){i_signed & i_b[DATA_WIDTH-1]}}, i_b};
  assign prod  = a_x * b_x;
  assign o_sum = acc_q + prod;

  always_comb begin
    acc_d = acc_q;
    if (i_clear)   acc_d = '0;
    else if (i_en) acc_d = o_sum;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// rtl/matrix_mult_seq.sv - time-multiplexed matrix multiplier R = A x B
// One product per cycle, row-major over (r,c) with k innermost; result published on completion.
module matrix_mult_seq
  import matrix_mult_pkg::*;
#(
  parameter int M          = 5,
  parameter int K          = 5,
  parameter int N          = 5,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic                          i_calc,
  input  logic                          i_signed,
  input  logic [M*K*DATA_WIDTH-1:0]     i_matrix_1,
  input  logic [K*N*DATA_WIDTH-1:0]     i_matrix_2,
  output logic [M*N*OUT_WIDTH-1:0]      o_result,
  output logic                          o_busy,
  output logic                          o_ready,
  output logic                          o_overflow
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, K);
  localparam int RW        = cnt_width(M);
  localparam int CW        = cnt_width(N);
  localparam int KW        = cnt_width(K);
  localparam int A_BITS    = M * K * DATA_WIDTH;
  localparam int B_BITS    = K * N * DATA_WIDTH;
  localparam int R_BITS    = M * N * OUT_WIDTH;
  localparam int A_IW      = clog2(A_BITS);
  localparam int B_IW      = clog2(B_BITS);
  localparam int R_IW      = clog2(R_BITS);

  localparam logic [RW-1:0] R_LAST = RW'(M - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  state_t              state_q, state_d;
  logic [RW-1:0]       r_q, r_d;
  logic [CW-1:0]       c_q, c_d;
  logic [KW-1:0]       k_q, k_d;
  logic [A_BITS-1:0]   a_q, a_d;
  logic [B_BITS-1:0]   b_q, b_d;
  logic                sgn_q, sgn_d;
  logic [R_BITS-1:0]   work_q, work_d;
  logic                wovf_q, wovf_d;
  logic [R_BITS-1:0]   result_q, result_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                ovf_q, ovf_d;

  logic                  mac_clear, mac_en;
  logic [ACC_WIDTH-1:0]  mac_sum;
  logic [A_IW-1:0]       a_idx;
  logic [B_IW-1:0]       b_idx;
  logic [R_IW-1:0]       w_idx;
  logic [DATA_WIDTH-1:0] a_elem, b_elem;
  logic [CONV_W-1:0]     sum_ext;
  conv_t                 cv;
  logic                  unused_conv_hi;

  assign a_idx  = A_IW'(a_offset(int'(r_q), int'(k_q), K, DATA_WIDTH));
  assign b_idx  = B_IW'(b_offset(int'(k_q), int'(c_q), N, DATA_WIDTH));
  assign w_idx  = R_IW'(r_offset(int'(r_q), int'(c_q), N, OUT_WIDTH));
  assign a_elem = a_q[a_idx +: DATA_WIDTH];
  assign b_elem = b_q[b_idx +: DATA_WIDTH];

  mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_signed(sgn_q),
    .i_clear (mac_clear),
    .i_en    (mac_en),
    .i_a     (a_elem),
    .i_b     (b_elem),
    .o_sum   (mac_sum)
  );

  // The accumulator is a raw bit pattern; the captured mode decides how it extends.
  assign sum_ext        = {{(CONV_W-ACC_WIDTH){sgn_q & mac_sum[ACC_WIDTH-1]}}, mac_sum};
  assign cv             = convert(sum_ext, OUT_WIDTH, sgn_q, SATURATE);
  assign unused_conv_hi = ^cv.value[CONV_W-1:OUT_WIDTH];

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    work_d    = work_q;
    wovf_d    = wovf_q;
    result_d  = result_q;
    busy_d    = busy_q;
    ready_d   = 1'b0;
    ovf_d     = ovf_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_calc) begin
          a_d       = i_matrix_1;
          b_d       = i_matrix_2;
          sgn_d     = i_signed;
          r_d       = '0;
          c_d       = '0;
          k_d       = '0;
          mac_clear = 1'b1;
          wovf_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = MAC;
        end
      end
      MAC: begin
        if (k_q == K_LAST) begin
          mac_clear                  = 1'b1;
          k_d                        = '0;
          work_d[w_idx +: OUT_WIDTH] = cv.value[OUT_WIDTH-1:0];
          wovf_d                     = wovf_q | cv.ovf;
          if (c_q == C_LAST) begin
            c_d = '0;
            if (r_q == R_LAST) begin
              // Final element goes straight to the output alongside the buffer.
              r_d      = '0;
              result_d = work_d;
              ovf_d    = wovf_d;
              ready_d  = 1'b1;
              busy_d   = 1'b0;
              state_d  = IDLE;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          mac_en = 1'b1;
          k_d    = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      work_q   <= '0;
      wovf_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      work_q   <= work_d;
      wovf_q   <= wovf_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_result   = result_q;
  assign o_busy     = busy_q;
  assign o_ready    = ready_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb/tb_matrix_mult_seq.sv - self-checking bench for matrix_mult_seq
module tb_matrix_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // main instance: 2x3 times 3x2, 16-bit saturating results
  logic        calc_m, sgn_m;
  logic [47:0] a_bus_m, b_bus_m;
  logic [63:0] res_m;
  logic        busy_m, ready_m, ovf_m;

  // small 2x2x2 instances sharing stimulus
  logic        calc_s, sgn_s;
  logic [31:0] a_bus_s, b_bus_s;
  logic [31:0] res_sat, res_wrap;
  logic [63:0] res_s16;
  logic        busy_sat, ready_sat, ovf_sat;
  logic        busy_wrap, ready_wrap, ovf_wrap;
  logic        busy_s16, ready_s16, ovf_s16;

  matrix_mult_seq #(.M(2), .K(3), .N(2), .DATA_WIDTH(8), .OUT_WIDTH(16), .SATURATE(1'b1)) u_main (
    .clk(clk), .i_rst(rst), .i_calc(calc_m), .i_signed(sgn_m),
    .i_matrix_1(a_bus_m), .i_matrix_2(b_bus_m),
    .o_result(res_m), .o_busy(busy_m), .o_ready(ready_m), .o_overflow(ovf_m));

  matrix_mult_seq #(.M(2), .K(2), .N(2), .DATA_WIDTH(8), .OUT_WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .i_rst(rst), .i_calc(calc_s), .i_signed(sgn_s),
    .i_matrix_1(a_bus_s), .i_matrix_2(b_bus_s),
    .o_result(res_sat), .o_busy(busy_sat), .o_ready(ready_sat), .o_overflow(ovf_sat));

  matrix_mult_seq #(.M(2), .K(2), .N(2), .DATA_WIDTH(8), .OUT_WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .i_rst(rst), .i_calc(calc_s), .i_signed(sgn_s),
    .i_matrix_1(a_bus_s), .i_matrix_2(b_bus_s),
    .o_result(res_wrap), .o_busy(busy_wrap), .o_ready(ready_wrap), .o_overflow(ovf_wrap));

  matrix_mult_seq #(.M(2), .K(2), .N(2), .DATA_WIDTH(8), .OUT_WIDTH(16), .SATURATE(1'b1)) u_s16 (
    .clk(clk), .i_rst(rst), .i_calc(calc_s), .i_signed(sgn_s),
    .i_matrix_1(a_bus_s), .i_matrix_2(b_bus_s),
    .o_result(res_s16), .o_busy(busy_s16), .o_ready(ready_s16), .o_overflow(ovf_s16));

  // reference model state: raw element bytes in, expected elements out
  int     av[6];
  int     bv[6];
  longint exp_r[4];
  bit     exp_ovf;

  function automatic longint sx(input int x, input bit sgn);
    return (sgn && x >= 128) ? longint'(x - 256) : longint'(x);
  endfunction

  task automatic model(input int m, input int kk, input int n, input int ow,
                       input bit sat, input bit sgn);
    longint s, lo, hi, mask;
    mask    = (longint'(1) << ow) - 1;
    if (sgn) begin
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -hi - 1;
    end else begin
      hi = mask;
      lo = 0;
    end
    exp_ovf = 1'b0;
    for (int i = 0; i < 4; i++) exp_r[i] = 0;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int q = 0; q < kk; q++) s += sx(av[r*kk+q], sgn) * sx(bv[q*n+c], sgn);
        if (s > hi || s < lo) exp_ovf = 1'b1;
        if (sat) s = (s > hi) ? hi : ((s < lo) ? lo : s);
        exp_r[r*n+c] = s & mask;
      end
    end
  endtask

  task automatic load_main();
    for (int i = 0; i < 6; i++) begin
      a_bus_m[i*8 +: 8] = 8'(av[i]);
      b_bus_m[i*8 +: 8] = 8'(bv[i]);
    end
  endtask

  task automatic load_small();
    for (int i = 0; i < 4; i++) begin
      a_bus_s[i*8 +: 8] = 8'(av[i]);
      b_bus_s[i*8 +: 8] = 8'(bv[i]);
    end
  endtask

  task automatic randomize_mats();
    for (int i = 0; i < 6; i++) begin
      av[i] = int'($urandom_range(0, 255));
      bv[i] = int'($urandom_range(0, 255));
    end
  endtask

  // Ends at the negedge where ready is seen; cyc counts edges after the capture edge.
  task automatic wait_ready_main(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ready_m) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL main_ready_timeout: no o_ready after %0d cycles, required within 200", cyc);
    end
  endtask

  task automatic run_main(output int cyc);
    @(negedge clk);
    calc_m = 1'b1;
    @(negedge clk);
    calc_m = 1'b0;
    wait_ready_main(cyc);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    calc_m = 1'b0; sgn_m = 1'b0; a_bus_m = '0; b_bus_m = '0;
    calc_s = 1'b0; sgn_s = 1'b0; a_bus_s = '0; b_bus_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({res_m, busy_m, ready_m, ovf_m} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_main: got result=%h busy=%b ready=%b ovf=%b, required all 0", res_m, busy_m, ready_m, ovf_m);
    end
    n_checks++;
    if ({res_sat, busy_sat, ready_sat, ovf_sat} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_small: got result=%h busy=%b ready=%b ovf=%b, required all 0", res_sat, busy_sat, ready_sat, ovf_sat);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    int golden[4] = '{58, 64, 139, 154};
    av = '{1, 2, 3, 4, 5, 6};
    bv = '{7, 8, 9, 10, 11, 12};
    sgn_m = 1'b0;
    load_main();
    run_main(cyc);
    n_checks++;
    if (cyc !== 12) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, required 12", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (res_m[i*16 +: 16] !== 16'(golden[i])) begin
        n_fail++;
        $display("FAIL basic_elem%0d: got %0d, required %0d", i, res_m[i*16 +: 16], golden[i]);
      end
    end
    n_checks++;
    if (ovf_m !== 1'b0 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_flags: got ovf=%b busy=%b, required 0 0", ovf_m, busy_m);
    end
    @(negedge clk);
    n_checks++;
    if (ready_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_pulse: got ready=%b one cycle later, required 0", ready_m);
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int t = 0; t < 8; t++) begin
      randomize_mats();
      sgn_m = 1'($urandom_range(0, 1));
      model(2, 3, 2, 16, 1'b1, sgn_m);
      load_main();
      run_main(cyc);
      n_checks++;
      if (cyc !== 12) begin
        n_fail++;
        $display("FAIL random%0d_latency: got %0d, required 12", t, cyc);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (res_m[i*16 +: 16] !== 16'(exp_r[i])) begin
          n_fail++;
          $display("FAIL random%0d_elem%0d (signed=%b): got %h, required %h", t, i, sgn_m, res_m[i*16 +: 16], 16'(exp_r[i]));
        end
      end
      n_checks++;
      if (ovf_m !== exp_ovf) begin
        n_fail++;
        $display("FAIL random%0d_overflow: got %b, required %b", t, ovf_m, exp_ovf);
      end
    end
  endtask

  task automatic test_saturation();
    bit seen;
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 6; i++) begin
        av[i] = (mode == 0) ? 255 : 128;
        bv[i] = (mode == 0) ? 255 : 127;
      end
      sgn_s = (mode == 1);
      load_small();
      @(negedge clk);
      calc_s = 1'b1;
      @(negedge clk);
      calc_s = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (ready_sat) seen = 1'b1;
      end
      n_checks++;
      if (!seen || !ready_wrap || !ready_s16) begin
        n_fail++;
        $display("FAIL sat%0d_ready: got ready sat/wrap/s16=%b%b%b, required 111", mode, ready_sat, ready_wrap, ready_s16);
      end
      model(2, 2, 2, 8, 1'b1, sgn_s);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (res_sat[i*8 +: 8] !== 8'(exp_r[i])) begin
          n_fail++;
          $display("FAIL sat%0d_clamp8_elem%0d: got %h, required %h", mode, i, res_sat[i*8 +: 8], 8'(exp_r[i]));
        end
      end
      n_checks++;
      if (ovf_sat !== exp_ovf) begin
        n_fail++;
        $display("FAIL sat%0d_clamp8_ovf: got %b, required %b", mode, ovf_sat, exp_ovf);
      end
      model(2, 2, 2, 8, 1'b0, sgn_s);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (res_wrap[i*8 +: 8] !== 8'(exp_r[i])) begin
          n_fail++;
          $display("FAIL sat%0d_wrap8_elem%0d: got %h, required %h", mode, i, res_wrap[i*8 +: 8], 8'(exp_r[i]));
        end
      end
      n_checks++;
      if (ovf_wrap !== exp_ovf) begin
        n_fail++;
        $display("FAIL sat%0d_wrap8_ovf: got %b, required %b", mode, ovf_wrap, exp_ovf);
      end
      model(2, 2, 2, 16, 1'b1, sgn_s);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (res_s16[i*16 +: 16] !== 16'(exp_r[i])) begin
          n_fail++;
          $display("FAIL sat%0d_out16_elem%0d: got %h, required %h", mode, i, res_s16[i*16 +: 16], 16'(exp_r[i]));
        end
      end
      n_checks++;
      if (ovf_s16 !== exp_ovf) begin
        n_fail++;
        $display("FAIL sat%0d_out16_ovf: got %b, required %b", mode, ovf_s16, exp_ovf);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int          cyc;
    int          extra;
    logic [63:0] prev;
    randomize_mats();
    sgn_m = 1'b1;
    model(2, 3, 2, 16, 1'b1, 1'b1);
    load_main();
    prev = res_m;
    @(negedge clk);
    calc_m = 1'b1;
    @(negedge clk);
    calc_m = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_m !== 1'b1 || res_m !== prev) begin
      n_fail++;
      $display("FAIL busy_midrun: got busy=%b result=%h, required busy=1 result=%h", busy_m, res_m, prev);
    end
    calc_m  = 1'b1;
    sgn_m   = 1'b0;
    a_bus_m = {$urandom, $urandom};
    b_bus_m = {$urandom, $urandom};
    @(negedge clk);
    calc_m = 1'b0;
    wait_ready_main(cyc);
    n_checks++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL busy_latency: got %0d edges after the ignored pulse window, required 8", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (res_m[i*16 +: 16] !== 16'(exp_r[i])) begin
        n_fail++;
        $display("FAIL busy_elem%0d: got %h, required %h", i, res_m[i*16 +: 16], 16'(exp_r[i]));
      end
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (ready_m) extra++;
    end
    n_checks++;
    if (extra !== 0 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_single_ready: got %0d extra ready pulses busy=%b, required 0 and 0", extra, busy_m);
    end
  endtask

  task automatic test_back_to_back();
    int  cyc;
    bit  seen;
    randomize_mats();
    sgn_m = 1'b0;
    model(2, 3, 2, 16, 1'b1, 1'b0);
    load_main();
    run_main(cyc);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (res_m[i*16 +: 16] !== 16'(exp_r[i])) begin
        n_fail++;
        $display("FAIL b2b_first_elem%0d: got %h, required %h", i, res_m[i*16 +: 16], 16'(exp_r[i]));
      end
    end
    randomize_mats();
    sgn_m = 1'b1;
    model(2, 3, 2, 16, 1'b1, 1'b1);
    load_main();
    calc_m = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      calc_m = 1'b0;
      if (ready_m) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cyc !== 13) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles between ready pulses (seen=%b), required 13", cyc, seen);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (res_m[i*16 +: 16] !== 16'(exp_r[i])) begin
        n_fail++;
        $display("FAIL b2b_second_elem%0d: got %h, required %h", i, res_m[i*16 +: 16], 16'(exp_r[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int fired;
    int golden[4] = '{58, 64, 139, 154};
    av = '{1, 2, 3, 4, 5, 6};
    bv = '{7, 8, 9, 10, 11, 12};
    sgn_m = 1'b0;
    load_main();
    @(negedge clk);
    calc_m = 1'b1;
    @(negedge clk);
    calc_m = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({res_m, busy_m, ready_m, ovf_m} !== 67'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got result=%h busy=%b ready=%b ovf=%b, required all 0", res_m, busy_m, ready_m, ovf_m);
    end
    @(negedge clk);
    rst   = 1'b0;
    fired = 0;
    repeat (30) begin
      @(negedge clk);
      if (ready_m) fired++;
    end
    n_checks++;
    if (fired !== 0 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_ready: got %0d ready pulses busy=%b, required 0 and 0", fired, busy_m);
    end
    run_main(cyc);
    n_checks++;
    if (cyc !== 12) begin
      n_fail++;
      $display("FAIL rstmid_restart_latency: got %0d, required 12", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (res_m[i*16 +: 16] !== 16'(golden[i])) begin
        n_fail++;
        $display("FAIL rstmid_restart_elem%0d: got %0d, required %0d", i, res_m[i*16 +: 16], golden[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_saturation();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
